// File: rtl/full_sub_pkg.sv
// full_sub_pkg: shared constants for the full_sub ripple-borrow subtractor.
// Macro FULL_SUB_PIPE_EN selects the registered-input build.  Rev 1.0
`default_nettype none

package full_sub_pkg;

  localparam int WIDTH_DEFAULT = 1;

`ifdef FULL_SUB_PIPE_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

endpackage

`default_nettype wire

// File: rtl/full_sub_cell.sv
// full_sub_cell: one-bit full subtractor stage of the ripple-borrow chain.
// Rev 1.0
`default_nettype none

module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/full_sub.sv
// full_sub: registered WIDTH-bit a - b - bin with borrow-out and valid.
// Macro FULL_SUB_PIPE_EN adds an input register stage (latency 2 vs 1).  Rev 1.0
`default_nettype none

module full_sub
  import full_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             out_valid
);

  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic             sub_bin;
  logic             sub_valid;
  logic [WIDTH-1:0] sub_d;
  logic [WIDTH:0]   br;

`ifdef FULL_SUB_PIPE_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             bin_q;
  logic             valid_q;

  // Operands are only sampled on valid cycles so idle-bus values never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      bin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        bin_q <= bin;
      end
    end
  end

  assign sub_a     = a_q;
  assign sub_b     = b_q;
  assign sub_bin   = bin_q;
  assign sub_valid = valid_q;
`else
  assign sub_a     = a;
  assign sub_b     = b;
  assign sub_bin   = bin;
  assign sub_valid = in_valid;
`endif

  assign br[0] = sub_bin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_sub_cell u_cell (
        .a   (sub_a[i]),
        .b   (sub_b[i]),
        .bin (br[i]),
        .d   (sub_d[i]),
        .bo  (br[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff      <= '0;
      bo        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sub_valid;
      if (sub_valid) begin
        diff <= sub_d;
        bo   <= br[WIDTH];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_full_sub.sv
// tb_full_sub: table-driven and randomised checks of full_sub at WIDTH 1, 8 and 16.
`default_nettype none

module tb_full_sub;

`ifdef FULL_SUB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        bin;
  logic        a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        d1, bo1, ov1;
  logic [7:0]  d8;
  logic        bo8, ov8;
  logic [15:0] d16;
  logic        bo16, ov16;

  int errors = 0;
  int checks = 0;

  full_sub #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .bin(bin), .in_valid(in_valid),
    .diff(d1), .bo(bo1), .out_valid(ov1)
  );
  full_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .bin(bin), .in_valid(in_valid),
    .diff(d8), .bo(bo8), .out_valid(ov8)
  );
  full_sub #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .bin(bin), .in_valid(in_valid),
    .diff(d16), .bo(bo16), .out_valid(ov16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  // Reference model: output registers plus optional input stage
  logic        mov;
  logic        md1, mb1;
  logic [7:0]  md8;
  logic        mb8;
  logic [15:0] md16;
  logic        mb16;
  logic        ms_v;
  logic [15:0] ms_a, ms_b;
  logic        ms_bin;

  function automatic logic [16:0] ref_sub(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic c);
    logic [16:0] mask;
    logic [16:0] r;
    mask = (17'd1 << w) - 17'd1;
    r = ({1'b0, x} & mask) - ({1'b0, y} & mask) - {16'd0, c};
    return {r[w], (r[15:0] & mask[15:0])};
  endfunction

  task automatic model_apply(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] r;
    r = ref_sub(1, x, y, c);   md1  = r[0];      mb1  = r[16];
    r = ref_sub(8, x, y, c);   md8  = r[7:0];    mb8  = r[16];
    r = ref_sub(16, x, y, c);  md16 = r[15:0];   mb16 = r[16];
  endtask

  task automatic model_reset();
    mov = 0; md1 = 0; mb1 = 0; md8 = 0; mb8 = 0; md16 = 0; mb16 = 0;
    ms_v = 0; ms_a = 0; ms_b = 0; ms_bin = 0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] x, input logic [15:0] y,
                            input logic c);
    if (LAT == 2) begin
      if (ms_v) model_apply(ms_a, ms_b, ms_bin);
      mov  = ms_v;
      ms_v = v;
      if (v) begin ms_a = x; ms_b = y; ms_bin = c; end
    end else begin
      if (v) model_apply(x, y, c);
      mov = v;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("w1_out_valid", 16'(ov1), 16'(mov));
    chk("w1_diff", 16'(d1), 16'(md1));
    chk("w1_bo", 16'(bo1), 16'(mb1));
    chk("w8_out_valid", 16'(ov8), 16'(mov));
    chk("w8_diff", 16'(d8), 16'(md8));
    chk("w8_bo", 16'(bo8), 16'(mb8));
    chk("w16_out_valid", 16'(ov16), 16'(mov));
    chk("w16_diff", d16, md16);
    chk("w16_bo", 16'(bo16), 16'(mb16));
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic c);
    in_valid = v;
    a16 = x;  b16 = y;
    a8  = x[7:0]; b8 = y[7:0];
    a1  = x[0];   b1 = y[0];
    bin = c;
  endtask

  // One clock: drive, advance DUT and model together, compare 1 time unit after the edge
  task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic c);
    drive(v, x, y, c);
    @(posedge clk);
    model_edge(v, x, y, c);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t tt[8];
  vec_t wr[2];

  initial begin
    int lat_cnt;
    int j;

    tt[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    tt[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1};
    tt[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1};
    tt[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    tt[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    tt[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0};
    tt[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0};
    tt[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};
    wr[0] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    wr[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};

    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;

    // Exhaustive 1-bit truth table, back-to-back
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      if (i < 8) cycle(1'b1, 16'(tt[i].a), 16'(tt[i].b), tt[i].bin);
      else       cycle(1'b0, 16'($urandom), 16'($urandom), 1'b1);
      j = i - (LAT - 1);
      if (j >= 0 && j < 8) begin
        chk("tt_out_valid", 16'(ov1), 16'd1);
        chk("tt_diff", 16'(d1), 16'(tt[j].d[0]));
        chk("tt_bo", 16'(bo1), 16'(tt[j].bo));
      end
    end

    // 8-bit wrap and MSB-borrow boundaries
    for (int i = 0; i < 2 + LAT - 1; i++) begin
      if (i < 2) cycle(1'b1, 16'(wr[i].a), 16'(wr[i].b), wr[i].bin);
      else       cycle(1'b0, 16'd0, 16'd0, 1'b0);
      j = i - (LAT - 1);
      if (j >= 0 && j < 2) begin
        chk("wrap_diff", 16'(d8), 16'(wr[j].d));
        chk("wrap_bo", 16'(bo8), 16'(wr[j].bo));
      end
    end

    // a == b with no borrow-in
    cycle(1'b1, 16'h5A5A, 16'h5A5A, 1'b0);
    repeat (LAT) cycle(1'b0, 16'hFFFF, 16'h0001, 1'b1);
    chk("eq_diff", d16, 16'h0000);
    chk("eq_bo", 16'(bo16), 16'd0);

    // Hold: result stays while idle operands change
    cycle(1'b1, 16'd1, 16'd0, 1'b0);
    repeat (LAT + 2) cycle(1'b0, 16'd0, 16'd1, 1'b0);
    chk("hold_diff", 16'(d8), 16'd1);
    chk("hold_bo", 16'(bo8), 16'd0);
    chk("hold_out_valid", 16'(ov8), 16'd0);

    // Latency measurement
    drive(1'b1, 16'h0010, 16'h0003, 1'b0);
    @(posedge clk);
    model_edge(1'b1, 16'h0010, 16'h0003, 1'b0);
    #1;
    lat_cnt = 1;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    while (!ov16 && lat_cnt < 10) begin
      @(posedge clk);
      model_edge(1'b0, 16'd0, 16'd0, 1'b0);
      #1;
      lat_cnt++;
    end
    chk("latency", 16'(lat_cnt), 16'(LAT));
    chk("latency_diff", d16, 16'h000D);
    cycle(1'b0, 16'd0, 16'd0, 1'b0);

    // Asynchronous reset with a result in flight
    cycle(1'b1, 16'h0035, 16'h0003, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (LAT + 1) cycle(1'b0, 16'hABCD, 16'h1234, 1'b1);
    chk("post_reset_out_valid", 16'(ov16), 16'd0);

    // Recovery: capture on the first edge after release, then latency as usual
    cycle(1'b1, 16'h1000, 16'h0001, 1'b0);
    repeat (LAT - 1) cycle(1'b0, 16'd0, 16'd0, 1'b0);
    chk("recover_diff", d16, 16'h0FFF);
    chk("recover_out_valid", 16'(ov16), 16'd1);

    // Random traffic with idle gaps
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)));
    end
    repeat (LAT) cycle(1'b0, 16'd0, 16'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
